// File: rtl/io_port_responder.sv
// Device-side responder for the processor I/O port: OUT writes feed a TX FIFO to an
// external sink, an RX holding register feeds IN reads, plus a level interrupt with ack.
module io_port_responder #(
  parameter int DATA_W   = 16,
  parameter int TX_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        out_wr,
  input  logic [DATA_W-1:0]           out_data,
  output logic [DATA_W-1:0]           out_last,
  input  logic                        in_rd,
  output logic [DATA_W-1:0]           in_data,
  output logic                        in_valid,
  output logic                        int_req,
  input  logic                        int_ack,
  input  logic [1:0]                  irq_mask,
  input  logic                        ext_irq,
  output logic [DATA_W-1:0]           ext_tx_data,
  output logic                        ext_tx_valid,
  input  logic                        ext_tx_ready,
  input  logic [DATA_W-1:0]           ext_rx_data,
  input  logic                        ext_rx_valid,
  output logic                        ext_rx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic                        tx_overflow,
  output logic                        rx_underrun,
  input  logic                        clr_status
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_ACKED} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] mem [TX_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, push, pop;

  assign full         = (tx_count == CW'(TX_DEPTH));
  assign ext_tx_valid = (tx_count != '0);
  assign ext_tx_data  = mem[rd_ptr];
  assign pop          = ext_tx_valid & ext_tx_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign push         = out_wr & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
      out_last <= '0;
      for (int i = 0; i < TX_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (out_wr) out_last <= out_data;
      if (push) begin
        mem[wr_ptr] <= out_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- RX holding register ----------------
  logic rx_load;

  assign ext_rx_ready = ~in_valid;
  assign rx_load      = ext_rx_valid & ~in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_data  <= '0;
      in_valid <= 1'b0;
    end else if (rx_load) begin
      in_data  <= ext_rx_data;
      in_valid <= 1'b1;
    end else if (in_rd) begin
      in_valid <= 1'b0;
    end
  end

  // ---------------- Sticky status ----------------
  // Set terms sit outside the clear mask so a coincident event survives clr_status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overflow <= 1'b0;
      rx_underrun <= 1'b0;
    end else begin
      tx_overflow <= (out_wr & ~push)    | (tx_overflow & ~clr_status);
      rx_underrun <= (in_rd & ~in_valid) | (rx_underrun & ~clr_status);
    end
  end

  // ---------------- ext_irq synchronizer + edge detect ----------------
  logic [2:0] irq_sync;
  logic       irq_edge, ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_sync <= '0;
    else     irq_sync <= {irq_sync[1:0], ext_irq};
  end

  assign irq_edge = irq_sync[1] & ~irq_sync[2];
  assign ev       = (rx_load & irq_mask[0]) | (irq_edge & irq_mask[1]);

  // ---------------- Interrupt FSM ----------------
  state_t state;
  logic   pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pend    <= 1'b0;
      int_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ev) begin
            state   <= S_ASSERT;
            int_req <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (ev) pend <= 1'b1;
          if (int_ack) begin
            state   <= S_ACKED;
            int_req <= 1'b0;
          end
        end
        S_ACKED: begin
          // An event landing in the ack gap is folded into the re-assert.
          if (pend | ev) begin
            state   <= S_ASSERT;
            int_req <= 1'b1;
            pend    <= 1'b0;
          end else begin
            state   <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          int_req <= 1'b0;
          pend    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: queue-based reference model compared every
// cycle, plus literal expectations at the key points of each scenario.
module tb_io_port_responder;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          out_wr = 0, in_rd = 0, int_ack = 0, ext_irq = 0;
  logic          ext_tx_ready = 0, ext_rx_valid = 0, clr_status = 0;
  logic [1:0]    irq_mask = 2'b00;
  logic [DW-1:0] out_data = '0, ext_rx_data = '0;
  logic [DW-1:0] out_last, in_data, ext_tx_data;
  logic          in_valid, int_req, ext_tx_valid, ext_rx_ready, tx_overflow, rx_underrun;
  logic [CW-1:0] tx_count;

  int tests = 0;
  int fails = 0;
  bit armed = 0;

  io_port_responder #(.DATA_W(DW), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .out_wr(out_wr), .out_data(out_data), .out_last(out_last),
    .in_rd(in_rd), .in_data(in_data), .in_valid(in_valid),
    .int_req(int_req), .int_ack(int_ack), .irq_mask(irq_mask), .ext_irq(ext_irq),
    .ext_tx_data(ext_tx_data), .ext_tx_valid(ext_tx_valid), .ext_tx_ready(ext_tx_ready),
    .ext_rx_data(ext_rx_data), .ext_rx_valid(ext_rx_valid), .ext_rx_ready(ext_rx_ready),
    .tx_count(tx_count), .tx_overflow(tx_overflow), .rx_underrun(rx_underrun),
    .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_last = '0, m_in_data = '0;
  bit            m_in_valid = 0, m_ovf = 0, m_und = 0;
  bit            m_req = 0, m_gap = 0, m_pend = 0;
  bit [2:0]      m_hist = '0;   // ext_irq as sampled at the last three edges, [0] newest

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_last = '0; m_in_data = '0; m_in_valid = 0; m_ovf = 0; m_und = 0;
      m_req = 0; m_gap = 0; m_pend = 0; m_hist = '0;
    end else begin
      bit pop_e, push_e, load_e, und_e, irq_e, ev_e;
      pop_e  = (m_q.size() != 0) && ext_tx_ready;
      push_e = out_wr && ((m_q.size() < DEPTH) || pop_e);
      load_e = ext_rx_valid && !m_in_valid;
      und_e  = in_rd && !m_in_valid;
      irq_e  = m_hist[1] && !m_hist[2];
      ev_e   = (load_e && irq_mask[0]) || (irq_e && irq_mask[1]);

      if (out_wr) m_last = out_data;
      if (pop_e)  void'(m_q.pop_front());
      if (push_e) m_q.push_back(out_data);
      if (out_wr && !push_e) m_ovf = 1; else if (clr_status) m_ovf = 0;
      if (und_e) m_und = 1; else if (clr_status) m_und = 0;
      if (load_e) begin m_in_data = ext_rx_data; m_in_valid = 1; end
      else if (in_rd) m_in_valid = 0;
      m_hist = {m_hist[1:0], ext_irq};

      if (m_req) begin
        if (ev_e) m_pend = 1;
        if (int_ack) begin m_req = 0; m_gap = 1; end
      end else if (m_gap) begin
        m_gap = 0;
        if (m_pend || ev_e) begin m_req = 1; m_pend = 0; end
      end else if (ev_e) begin
        m_req = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc tx_count",     32'(tx_count),     32'(m_q.size()));
      chk("cyc ext_tx_valid", 32'(ext_tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("cyc ext_tx_data", 32'(ext_tx_data), 32'(m_q[0]));
      chk("cyc out_last",     32'(out_last),     32'(m_last));
      chk("cyc in_data",      32'(in_data),      32'(m_in_data));
      chk("cyc in_valid",     32'(in_valid),     32'(m_in_valid));
      chk("cyc ext_rx_ready", 32'(ext_rx_ready), 32'(!m_in_valid));
      chk("cyc tx_overflow",  32'(tx_overflow),  32'(m_ovf));
      chk("cyc rx_underrun",  32'(rx_underrun),  32'(m_und));
      chk("cyc int_req",      32'(int_req),      32'(m_req));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    out_data = d; out_wr = 1; step(); out_wr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_v [4];
    step(2);
    rst = 0;
    armed = 1;
    step();
    chk("reset tx_count", 32'(tx_count), 0);
    chk("reset int_req",  32'(int_req),  0);

    // async reset with 2 entries in the FIFO and int_req high
    push_word(16'h0A0A);
    push_word(16'h0B0B);
    irq_mask = 2'b01; ext_rx_data = 16'h1234; ext_rx_valid = 1; step(); ext_rx_valid = 0;
    chk("pre-reset tx_count", 32'(tx_count), 2);
    chk("pre-reset int_req",  32'(int_req),  1);
    rst = 1; #1;
    chk("async rst tx_count",    32'(tx_count),     0);
    chk("async rst tx_valid",    32'(ext_tx_valid), 0);
    chk("async rst tx_data",     32'(ext_tx_data),  0);
    chk("async rst int_req",     32'(int_req),      0);
    chk("async rst in_valid",    32'(in_valid),     0);
    chk("async rst in_data",     32'(in_data),      0);
    chk("async rst out_last",    32'(out_last),     0);
    step(); rst = 0; irq_mask = 2'b00; step();

    // fill past full, then drain in order
    ext_tx_ready = 0;
    push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
    push_word(16'h4444); push_word(16'h5555);
    chk("full tx_count",    32'(tx_count),    4);
    chk("full tx_overflow", 32'(tx_overflow), 1);
    chk("full out_last",    32'(out_last),    32'h5555);
    exp_v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    ext_tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain head", 32'(ext_tx_data), 32'(exp_v[i]));
      step();
    end
    ext_tx_ready = 0;
    chk("drained valid", 32'(ext_tx_valid), 0);
    clr_status = 1; step(); clr_status = 0;
    chk("ovf cleared", 32'(tx_overflow), 0);

    // full with simultaneous push and pop
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003); push_word(16'h0004);
    ext_tx_ready = 1; push_word(16'hAAAA);
    chk("push+pop tx_count", 32'(tx_count),    4);
    chk("push+pop ovf",      32'(tx_overflow), 0);
    exp_v = '{16'h0002, 16'h0003, 16'h0004, 16'hAAAA};
    for (int i = 0; i < 4; i++) begin
      chk("wrap head", 32'(ext_tx_data), 32'(exp_v[i]));
      step();
    end
    ext_tx_ready = 0;

    // RX load with interrupt, ack, read
    irq_mask = 2'b01; ext_rx_data = 16'hBEEF; ext_rx_valid = 1; step(); ext_rx_valid = 0;
    chk("rx in_data",  32'(in_data),      32'hBEEF);
    chk("rx in_valid", 32'(in_valid),     1);
    chk("rx int_req",  32'(int_req),      1);
    chk("rx ready",    32'(ext_rx_ready), 0);
    ext_rx_data = 16'h7777; ext_rx_valid = 1; step(); ext_rx_valid = 0;
    chk("rx held",     32'(in_data),      32'hBEEF);
    int_ack = 1; step(); int_ack = 0;
    chk("ack int_req", 32'(int_req), 0);
    step();
    chk("idle int_req", 32'(int_req), 0);
    in_rd = 1; step(); in_rd = 0;
    chk("rd in_valid", 32'(in_valid),     0);
    chk("rd ready",    32'(ext_rx_ready), 1);
    chk("rd in_data",  32'(in_data),      32'hBEEF);

    // underrun sticky / clear / set-wins
    in_rd = 1; step(); in_rd = 0;
    chk("underrun set", 32'(rx_underrun), 1);
    clr_status = 1; step(); clr_status = 0;
    chk("underrun clr", 32'(rx_underrun), 0);
    in_rd = 1; clr_status = 1; step(); in_rd = 0; clr_status = 0;
    chk("underrun wins", 32'(rx_underrun), 1);
    clr_status = 1; step(); clr_status = 0;

    // masked RX arrival leaves int_req low
    irq_mask = 2'b10; ext_rx_data = 16'h5A5A; ext_rx_valid = 1; step(); ext_rx_valid = 0;
    chk("masked rx int_req", 32'(int_req), 0);
    in_rd = 1; step(); in_rd = 0;

    // ext_irq edge, two coalesced pulses during ASSERT
    ext_irq = 1; step(2); ext_irq = 0;
    chk("irq not yet", 32'(int_req), 0);
    step();
    chk("irq asserted", 32'(int_req), 1);
    for (int p = 0; p < 2; p++) begin
      step(2); ext_irq = 1; step(2); ext_irq = 0;
    end
    step(4);
    chk("still asserted", 32'(int_req), 1);
    int_ack = 1; step(); int_ack = 0;
    chk("acked gap", 32'(int_req), 0);
    step();
    chk("reassert", 32'(int_req), 1);
    step(2);
    int_ack = 1; step(); int_ack = 0;
    chk("ack2 gap", 32'(int_req), 0);
    step(3);
    chk("back idle", 32'(int_req), 0);

    armed = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Device-side responder for the processor's 16-bit I/O port interface and interrupt line.
- OUT-instruction writes are captured into a TX FIFO and drained to an external sink over valid/ready.
- External source data is accepted into an RX holding register, which IN instructions consume.
- Raises a level interrupt request with an acknowledge handshake on RX arrival or an external IRQ edge.
- Sits between the processor core's inputPort/outputPort/interrupt pins and board-level peripherals.

Parameters:
- DATA_W, 16, port data width.
- TX_DEPTH, 4, TX FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- out_wr  input  1  one-cycle strobe: processor OUT, push out_data.
- out_data  input  DATA_W  OUT value.
- out_last  output  DATA_W  last value accepted by out_wr.
- in_rd  input  1  one-cycle strobe: processor IN consumed in_data.
- in_data  output  DATA_W  RX holding register.
- in_valid  output  1  RX holding register full.
- int_req  output  1  interrupt request to processor.
- int_ack  input  1  processor acknowledge.
- irq_mask  input  2  bit0 enables RX-arrival interrupt, bit1 enables ext_irq interrupt.
- ext_irq  input  1  asynchronous external interrupt pin.
- ext_tx_data  output  DATA_W  FIFO head.
- ext_tx_valid  output  1  FIFO not empty.
- ext_tx_ready  input  1  sink ready.
- ext_rx_data  input  DATA_W  source data.
- ext_rx_valid  input  1  source valid.
- ext_rx_ready  output  1  equals ~in_valid.
- tx_count  output  clog2(TX_DEPTH)+1  FIFO occupancy.
- tx_overflow  output  1  sticky: out_wr dropped.
- rx_underrun  output  1  sticky: in_rd with RX empty.
- clr_status  input  1  clears both sticky flags.

Behaviour:
- Reset (async, immediate):
  - Pointers, tx_count, out_last, in_data, in_valid, int_req, sticky flags and synchronizers all 0.
  - Interrupt FSM to IDLE; pending bits to 0.
  - Reset mid-transfer discards FIFO contents and any pending interrupt.
- TX FIFO:
  - Push when out_wr and (not full, or pop in the same cycle).
  - Pop when ext_tx_valid and ext_tx_ready.
  - ext_tx_data is mem[rd_ptr], combinational from the registered array.
  - Latency: out_wr at edge N into an empty FIFO gives ext_tx_valid=1 after edge N.
  - Pointers wrap modulo TX_DEPTH.
  - tx_count: +1 on push only, -1 on pop only, unchanged on both.
  - Full: out_wr without a pop is dropped and tx_overflow sets; FIFO contents are unchanged.
  - Full with simultaneous pop and push: both occur and tx_count stays at TX_DEPTH.
  - out_last updates on every out_wr, including dropped ones.
- RX:
  - ext_rx_ready = ~in_valid, combinational.
  - Transfer (ext_rx_valid and ext_rx_ready) at edge N loads in_data and sets in_valid after edge N.
  - in_rd with in_valid clears in_valid; in_data holds its value.
  - in_rd with in_valid=0 sets rx_underrun and changes nothing else.
  - A same-cycle load and read is impossible by construction.
- Sticky flags:
  - clr_status clears tx_overflow and rx_underrun.
  - A set event in the same cycle as clr_status wins, so the flag ends at 1.
- ext_irq:
  - Two-flop synchronizer, then rising-edge detect (sync2 & ~sync3).
  - The edge event fires 3 edges after the pin rises.
- Interrupt events:
  - ev = (rx_load & irq_mask[0]) | (irq_edge & irq_mask[1]).
- FSM states:
  - IDLE: int_req=0. On ev go to ASSERT.
  - ASSERT: int_req=1. On int_ack go to ACKED.
  - ACKED: int_req=0 for exactly one cycle. Then go to ASSERT if pend=1 (clearing pend), else IDLE.
  - Any ev in ASSERT or ACKED sets the single pend bit; multiple events coalesce.
  - Transitions are registered, so an rx_load at edge N makes int_req=1 after edge N, together with in_valid.
  - int_ack in IDLE or ACKED is ignored.
  - A masked event is dropped and not remembered.

Test Plan:
- Reset with FIFO holding 2 entries and int_req=1 -> all outputs 0 immediately, before the next clock edge.
- TX_DEPTH=4, ext_tx_ready=0, out_wr 0x1111,0x2222,0x3333,0x4444,0x5555 -> tx_count=4, tx_overflow=1, out_last=0x5555; then ready=1 drains 0x1111..0x4444 in order, one per cycle.
- FIFO full, same-cycle out_wr 0xAAAA and ext_tx_ready=1 -> head popped, 0xAAAA accepted, tx_count stays 4, tx_overflow unchanged.
- ext_rx_valid with data 0xBEEF, irq_mask=01:
  - in_data=0xBEEF, in_valid=1 and int_req=1 after the same edge; ext_rx_ready=0.
  - int_ack -> int_req low one cycle later.
  - in_rd -> in_valid=0, ext_rx_ready=1.
- in_rd with in_valid=0 -> rx_underrun=1; clr_status -> 0; clr_status with a simultaneous underrun -> stays 1.
- irq_mask=10, ext_irq pulses twice while in ASSERT -> after int_ack: one ACKED cycle with int_req=0, then int_req=1 again once (coalesced), then IDLE after the second ack.
